// File: rtl/lcd_frame_sched.sv
// ---------------------------------------------------------------------------
// lcd_frame_sched
//   Read-side scheduler that sits between the SDRAM read port / pixel FIFO and
//   the RGB LCD timing driver. Everything runs on lcd_clk.
//   - Prefetches each frame from SDRAM in bursts so that the pixel FIFO stays
//     ahead of the driver's data_req.
//   - Returns pixel_data one cycle after each data_req. The output is black
//     when the FIFO cannot serve the request.
//   - Flushes the FIFO during vertical blank and restarts the fetch at the
//     start of the frame.
//   - Selects the ping-pong frame bank for the reader and for the writer.
//
// Ports
//   lcd_clk, sys_rst_n       : clock and asynchronous active-low reset
//   data_req, pixel_xpos/ypos: driver request and its pixel position
//   pixel_data               : RGB565 to the driver, 1 cycle after data_req
//   fifo_rd_en/rd_data/empty/usedw/flush : pixel FIFO read side
//   rd_req/rd_addr/rd_len/rd_ack/rd_done : SDRAM burst read port
//   wr_frame_done            : writer finished a frame (pulse)
//   wr_bank, rd_bank         : bank to write / bank being displayed
//   underflow_cnt            : saturating count of unserved requests
//
// Build option
//   LCD_SCHED_UFLOW_CNT_EN : when defined, underflow_cnt is a live counter.
//                            Otherwise underflow_cnt is tied to zero.
// ---------------------------------------------------------------------------
module lcd_frame_sched #(
  parameter logic [10:0] H_DISP     = 11'd800,
  parameter logic [10:0] V_DISP     = 11'd480,
  parameter logic [9:0]  BURST_LEN  = 10'd256,
  parameter logic [10:0] FIFO_DEPTH = 11'd1024,
  parameter logic [23:0] BANK0_BASE = 24'h000000,
  parameter logic [23:0] BANK1_BASE = 24'h100000,
  parameter logic [3:0]  FLUSH_CYC  = 4'd4
) (
  input  logic        lcd_clk,
  input  logic        sys_rst_n,
  input  logic        data_req,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  output logic [15:0] pixel_data,
  output logic        fifo_rd_en,
  input  logic [15:0] fifo_rd_data,
  input  logic        fifo_empty,
  input  logic [10:0] fifo_usedw,
  output logic        fifo_flush,
  output logic        rd_req,
  output logic [23:0] rd_addr,
  output logic [9:0]  rd_len,
  input  logic        rd_ack,
  input  logic        rd_done,
  input  logic        wr_frame_done,
  output logic        wr_bank,
  output logic        rd_bank,
  output logic [15:0] underflow_cnt
);

  typedef enum logic [2:0] {
    S_FLUSH = 3'd0,
    S_IDLE  = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [19:0] FRAME_W = 20'(H_DISP) * 20'(V_DISP);

  state_t      state, state_nxt;
  logic [19:0] fetched;      // words requested so far in this frame
  logic [3:0]  flush_cnt;
  logic        frame_pend;   // frame end seen while a fetch was still running
  logic        swap_pend;
  logic        pix_vld;
  logic        frame_end, first_flush, flush_last, room;
  logic [19:0] remain;
  logic [9:0]  burst_len;

  assign frame_end   = data_req && (pixel_xpos == H_DISP - 11'd1) &&
                       (pixel_ypos == V_DISP);
  assign first_flush = (state == S_FLUSH) && (flush_cnt == 4'd0);
  assign flush_last  = (state == S_FLUSH) && (flush_cnt == FLUSH_CYC - 4'd1);
  // Only start a burst if the whole burst fits, with one slot kept spare.
  assign room        = ({1'b0, fifo_usedw} + {2'b0, BURST_LEN}) <=
                       ({1'b0, FIFO_DEPTH} - 12'd1);
  assign remain      = FRAME_W - fetched;
  assign burst_len   = (remain < {10'd0, BURST_LEN}) ? remain[9:0] : BURST_LEN;

  // State register
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_FLUSH;
    else            state <= state_nxt;
  end

  // Next-state logic. An accepted burst is always allowed to complete. A frame
  // end seen during a fetch is latched and acted on back in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FLUSH: if (flush_last) state_nxt = S_IDLE;
      S_IDLE: begin
        if (frame_pend || frame_end) state_nxt = S_FLUSH;
        else if (fetched == FRAME_W) state_nxt = S_DONE;
        else if (room)               state_nxt = S_REQ;
      end
      S_REQ:   if (rd_ack)  state_nxt = S_WAIT;
      S_WAIT:  if (rd_done) state_nxt = S_IDLE;
      S_DONE:  if (frame_end || frame_pend) state_nxt = S_FLUSH;
      default: state_nxt = S_FLUSH;
    endcase
  end

  // Outputs. Burst handshake: rd_req is a valid signal. rd_addr and rd_len
  // are held stable while rd_req is high. The transfer happens in the cycle
  // where rd_req && rd_ack, and rd_req drops on the next cycle.
  always_comb begin
    fifo_flush = (state == S_FLUSH);
    rd_req     = (state == S_REQ);
    rd_addr    = 24'd0;
    rd_len     = 10'd0;
    if (state == S_REQ) begin
      rd_addr = (rd_bank ? BANK1_BASE : BANK0_BASE) + {4'd0, fetched};
      rd_len  = burst_len;
    end
    fifo_rd_en = data_req && !fifo_empty && (state != S_FLUSH);
    pixel_data = pix_vld ? fifo_rd_data : 16'h0000;
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      flush_cnt  <= 4'd0;
      fetched    <= 20'd0;
      frame_pend <= 1'b0;
      swap_pend  <= 1'b0;
      rd_bank    <= 1'b0;
      pix_vld    <= 1'b0;
    end else begin
      pix_vld <= fifo_rd_en;

      if (state == S_FLUSH) flush_cnt <= flush_last ? 4'd0 : flush_cnt + 4'd1;
      else                  flush_cnt <= 4'd0;

      if (state == S_FLUSH)            fetched <= 20'd0;
      else if (state == S_REQ && rd_ack) fetched <= fetched + {10'd0, burst_len};

      if (state == S_FLUSH) frame_pend <= 1'b0;
      else if (frame_end && (state == S_IDLE || state == S_REQ || state == S_WAIT))
        frame_pend <= 1'b1;

      // The swap takes effect only at the start of a flush. A writer pulse
      // that arrives in that same cycle is consumed by the swap.
      if (first_flush && swap_pend) begin
        rd_bank   <= ~rd_bank;
        swap_pend <= 1'b0;
      end else if (wr_frame_done) begin
        swap_pend <= 1'b1;
      end
    end
  end

  assign wr_bank = ~rd_bank;

`ifdef LCD_SCHED_UFLOW_CNT_EN
  logic [15:0] uflow_q;
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) uflow_q <= 16'd0;
    else if (data_req && (fifo_empty || state == S_FLUSH) && uflow_q != 16'hFFFF)
      uflow_q <= uflow_q + 16'd1;
  end
  assign underflow_cnt = uflow_q;
`else
  assign underflow_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_lcd_frame_sched.sv
// ---------------------------------------------------------------------------
// tb_lcd_frame_sched
//   Self-checking bench for lcd_frame_sched.
//   dut   : 8x4 frame, BURST_LEN 8, FIFO_DEPTH 32, FLUSH_CYC 4
//   dut_b : 10x3 frame (30 words), used to check the short last burst
//   The expected burst addresses and lengths, pixel data and underflow count
//   are computed from frame arithmetic kept in the bench.
// ---------------------------------------------------------------------------
module tb_lcd_frame_sched;

  logic lcd_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 lcd_clk = ~lcd_clk;

  // instance A signals
  logic        data_req = 1'b0, fifo_empty = 1'b1, rd_ack = 1'b0, rd_done = 1'b0;
  logic        wr_frame_done = 1'b0;
  logic [10:0] pixel_xpos = 11'd0, pixel_ypos = 11'd1, fifo_usedw = 11'd31;
  logic [15:0] fifo_rd_data = 16'h0;
  logic [15:0] pixel_data, underflow_cnt;
  logic        fifo_rd_en, fifo_flush, rd_req, wr_bank, rd_bank;
  logic [23:0] rd_addr;
  logic [9:0]  rd_len;

  // instance B signals
  logic        rd_ack_b = 1'b0, rd_done_b = 1'b0;
  logic [15:0] pixel_data_b, underflow_cnt_b;
  logic        fifo_rd_en_b, fifo_flush_b, rd_req_b, wr_bank_b, rd_bank_b;
  logic [23:0] rd_addr_b;
  logic [9:0]  rd_len_b;

  lcd_frame_sched #(
    .H_DISP(11'd8), .V_DISP(11'd4), .BURST_LEN(10'd8), .FIFO_DEPTH(11'd32),
    .BANK0_BASE(24'h000000), .BANK1_BASE(24'h100000), .FLUSH_CYC(4'd4)
  ) dut (
    .lcd_clk(lcd_clk), .sys_rst_n(sys_rst_n), .data_req(data_req),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .pixel_data(pixel_data),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .fifo_usedw(fifo_usedw), .fifo_flush(fifo_flush), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack), .rd_done(rd_done),
    .wr_frame_done(wr_frame_done), .wr_bank(wr_bank), .rd_bank(rd_bank),
    .underflow_cnt(underflow_cnt)
  );

  lcd_frame_sched #(
    .H_DISP(11'd10), .V_DISP(11'd3), .BURST_LEN(10'd8), .FIFO_DEPTH(11'd32),
    .BANK0_BASE(24'h000000), .BANK1_BASE(24'h100000), .FLUSH_CYC(4'd4)
  ) dut_b (
    .lcd_clk(lcd_clk), .sys_rst_n(sys_rst_n), .data_req(1'b0),
    .pixel_xpos(11'd0), .pixel_ypos(11'd1), .pixel_data(pixel_data_b),
    .fifo_rd_en(fifo_rd_en_b), .fifo_rd_data(16'h0), .fifo_empty(1'b1),
    .fifo_usedw(11'd0), .fifo_flush(fifo_flush_b), .rd_req(rd_req_b),
    .rd_addr(rd_addr_b), .rd_len(rd_len_b), .rd_ack(rd_ack_b), .rd_done(rd_done_b),
    .wr_frame_done(1'b0), .wr_bank(wr_bank_b), .rd_bank(rd_bank_b),
    .underflow_cnt(underflow_cnt_b)
  );

  // scoreboard and reference state
  int checks = 0;
  int errors = 0;
  int uf_model = 0;
  int fetched_model = 0;
  logic bank_model = 1'b0;
  logic [15:0] exp_q[$];

  localparam int FRAME_A = 32;
  localparam int FRAME_B = 30;
  localparam int BURST   = 8;

  typedef struct {
    logic [10:0] usedw;
    logic        exp_req;
    int          hold;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [31:0] uf_exp(input int n);
`ifdef LCD_SCHED_UFLOW_CNT_EN
    return (n > 65535) ? 32'd65535 : 32'(n);
`else
    return (n > 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic wait_req_a(input int budget, output bit seen);
    int i;
    seen = 1'b0;
    i = 0;
    while (!seen && i < budget) begin
      @(negedge lcd_clk);
      if (rd_req === 1'b1) seen = 1'b1;
      i++;
    end
  endtask

  // Called at a negedge with rd_req high. Checks the request, holds off the
  // ack for 'hold' cycles, then accepts the request. Returns with the DUT in WAIT.
  task automatic req_ack_a(input int hold);
    logic [23:0] ea;
    logic [9:0]  el;
    ea = (bank_model ? 24'h100000 : 24'h000000) + 24'(fetched_model);
    el = 10'(imin(BURST, FRAME_A - fetched_model));
    chk("rd_addr", 32'(rd_addr), 32'(ea));
    chk("rd_len", 32'(rd_len), 32'(el));
    for (int i = 0; i < hold; i++) begin
      @(negedge lcd_clk);
      chk("hold_req", 32'(rd_req), 32'd1);
      chk("hold_addr", 32'(rd_addr), 32'(ea));
      chk("hold_len", 32'(rd_len), 32'(el));
    end
    rd_ack = 1'b1;
    @(negedge lcd_clk);
    rd_ack = 1'b0;
    chk("req_drop", 32'(rd_req), 32'd0);
    fetched_model += int'(el);
    fifo_usedw = 11'd31;  // the burst has filled the FIFO
  endtask

  task automatic finish_burst_a();
    repeat ($urandom_range(1, 3)) @(negedge lcd_clk);
    rd_done = 1'b1;
    @(negedge lcd_clk);
    rd_done = 1'b0;
  endtask

  // One pixel cycle: drive at this negedge, check at the next one.
  task automatic pix_step(input logic req, input logic emp, input logic [10:0] x,
                          input logic [10:0] y, input logic [15:0] w);
    data_req = req; fifo_empty = emp; pixel_xpos = x; pixel_ypos = y; fifo_rd_data = w;
    #1;
    chk("rd_en", 32'(fifo_rd_en), 32'(req && !emp));
    if (req && emp) uf_model++;
    exp_q.push_back((req && !emp) ? w : 16'h0000);
    @(negedge lcd_clk);
    chk("pixel", 32'(pixel_data), 32'(exp_q.pop_front()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    int fb;
    logic [9:0] eb;

    vecs[0] = '{11'd0,  1'b1, 0};
    vecs[1] = '{11'd24, 1'b0, 0};
    vecs[2] = '{11'd31, 1'b0, 0};
    vecs[3] = '{11'd23, 1'b1, 0};
    vecs[4] = '{11'd30, 1'b0, 0};
    vecs[5] = '{11'd0,  1'b1, 10};
    vecs[6] = '{11'd25, 1'b0, 0};
    vecs[7] = '{11'd16, 1'b1, 0};
    vecs[8] = '{11'd0,  1'b0, 0};  // frame fully fetched: no further burst

    // reset state
    repeat (2) @(negedge lcd_clk);
    chk("rst_flush", 32'(fifo_flush), 32'd1);
    chk("rst_wr_bank", 32'(wr_bank), 32'd1);
    chk("rst_rd_bank", 32'(rd_bank), 32'd0);
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_pixel", 32'(pixel_data), 32'd0);
    chk("rst_uflow", 32'(underflow_cnt), uf_exp(0));

    // flush lasts four cycles after reset release
    sys_rst_n = 1'b1;
    #1 chk("flush_c0", 32'(fifo_flush), 32'd1);
    for (int i = 1; i < 4; i++) begin
      @(negedge lcd_clk);
      chk("flush_cn", 32'(fifo_flush), 32'd1);
    end
    @(negedge lcd_clk);
    chk("flush_end", 32'(fifo_flush), 32'd0);

    // burst gating by FIFO fill level, one frame of fetch
    for (int i = 0; i < 9; i++) begin
      fifo_usedw = vecs[i].usedw;
      wait_req_a(4, seen);
      chk("req_gate", 32'(seen), 32'(vecs[i].exp_req));
      if (seen) begin
        req_ack_a(vecs[i].hold);
        finish_burst_a();
      end
    end
    chk("fetched_total", 32'(fetched_model), 32'(FRAME_A));

    // underflow: three requests against an empty FIFO
    for (int i = 0; i < 3; i++) pix_step(1'b1, 1'b1, 11'(i), 11'd1, 16'(16'hA5A0 + i));
    data_req = 1'b0;
    chk("uflow_3", 32'(underflow_cnt), uf_exp(3));
    chk("uflow_model", 32'(uf_model), 32'd3);

    // randomized pixel traffic without a frame end
    for (int i = 0; i < 200; i++)
      pix_step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
               11'($urandom_range(0, 7)), 11'($urandom_range(1, 3)), 16'($urandom));
    data_req = 1'b0;
    chk("uflow_rand", 32'(underflow_cnt), uf_exp(uf_model));

    // bank swap: two writer pulses count as one, applied at the frame flush
    wr_frame_done = 1'b1; @(negedge lcd_clk); wr_frame_done = 1'b0;
    @(negedge lcd_clk);
    wr_frame_done = 1'b1; @(negedge lcd_clk); wr_frame_done = 1'b0;
    chk("pre_swap_rd", 32'(rd_bank), 32'd0);
    chk("pre_swap_wr", 32'(wr_bank), 32'd1);
    data_req = 1'b1; fifo_empty = 1'b0; pixel_xpos = 11'd7; pixel_ypos = 11'd4;
    fifo_rd_data = 16'hBEEF;
    #1 chk("fe_rd_en", 32'(fifo_rd_en), 32'd1);
    @(negedge lcd_clk);
    chk("fe_pixel", 32'(pixel_data), 32'hBEEF);
    chk("fe_flush", 32'(fifo_flush), 32'd1);
    chk("fe_rd_bank", 32'(rd_bank), 32'd0);
    pixel_xpos = 11'd0; pixel_ypos = 11'd1;  // request during flush
    #1 chk("flush_rd_en", 32'(fifo_rd_en), 32'd0);
    uf_model++;
    @(negedge lcd_clk);
    data_req = 1'b0;
    chk("flush_pixel", 32'(pixel_data), 32'd0);
    chk("swap_rd_bank", 32'(rd_bank), 32'd1);
    chk("swap_wr_bank", 32'(wr_bank), 32'd0);
    chk("flush_uflow", 32'(underflow_cnt), uf_exp(uf_model));
    bank_model = 1'b1;
    fetched_model = 0;
    fifo_usedw = 11'd0;
    wait_req_a(10, seen);
    chk("bank1_req", 32'(seen), 32'd1);
    if (seen) req_ack_a(0);

    // reset while the burst is in WAIT
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(rd_req), 32'd0);
    chk("mid_rst_rd_bank", 32'(rd_bank), 32'd0);
    chk("mid_rst_wr_bank", 32'(wr_bank), 32'd1);
    chk("mid_rst_flush", 32'(fifo_flush), 32'd1);
    chk("mid_rst_uflow", 32'(underflow_cnt), 32'd0);
    uf_model = 0; bank_model = 1'b0; fetched_model = 0;
    @(negedge lcd_clk);
    sys_rst_n = 1'b1;
    fifo_usedw = 11'd0;
    wait_req_a(10, seen);
    chk("post_rst_req", 32'(seen), 32'd1);

    // frame end arriving while a burst is outstanding
    if (seen) req_ack_a(0);
    data_req = 1'b1; fifo_empty = 1'b0; pixel_xpos = 11'd7; pixel_ypos = 11'd4;
    @(negedge lcd_clk);
    data_req = 1'b0; pixel_xpos = 11'd0; pixel_ypos = 11'd1;
    chk("lag_no_flush", 32'(fifo_flush), 32'd0);
    finish_burst_a();
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (fifo_flush === 1'b1) seen = 1'b1;
      if (!seen) @(negedge lcd_clk);
    end
    chk("lag_flush", 32'(seen), 32'd1);
    fetched_model = 0;
    fifo_usedw = 11'd0;
    wait_req_a(10, seen);
    chk("lag_restart_req", 32'(seen), 32'd1);
    if (seen) begin
      req_ack_a(0);
      finish_burst_a();
    end

    // 30-word frame: last burst is short
    fb = 0;
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
        if (rd_req_b === 1'b1) seen = 1'b1;
        else @(negedge lcd_clk);
      end
      chk("b_req", 32'(seen), 32'd1);
      eb = 10'(imin(BURST, FRAME_B - fb));
      chk("b_addr", 32'(rd_addr_b), 32'(fb));
      chk("b_len", 32'(rd_len_b), 32'(eb));
      rd_ack_b = 1'b1; @(negedge lcd_clk); rd_ack_b = 1'b0;
      fb += int'(eb);
      @(negedge lcd_clk);
      rd_done_b = 1'b1; @(negedge lcd_clk); rd_done_b = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge lcd_clk);
      if (rd_req_b === 1'b1) seen = 1'b1;
    end
    chk("b_no_extra", 32'(seen), 32'd0);
    chk("b_total", 32'(fb), 32'(FRAME_B));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
